// File: rtl/systolic_matmul_tile.sv
// N x N output-stationary systolic tile computing C = A*B or C += A*B over inner dimension K_DIM.
// Define SYSTOLIC_SAT_EN for saturating accumulation with a sticky overflow flag; otherwise sums wrap.
module systolic_matmul_tile #(
   parameter int ARRAY_SIZE   = 4,
   parameter int K_DIM        = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACCUM_WIDTH  = 32
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 start,
   input  logic                                                 acc_mode,
   input  logic [DATA_WIDTH*ARRAY_SIZE*K_DIM-1:0]               matrix_a_flat,
   input  logic [WEIGHT_WIDTH*K_DIM*ARRAY_SIZE-1:0]             matrix_b_flat,
   output logic                                                 busy,
   output logic                                                 out_valid,
   input  logic                                                 out_ready,
   output logic [((ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1)-1:0] out_row_idx,
   output logic [ACCUM_WIDTH*ARRAY_SIZE-1:0]                    out_row,
   output logic                                                 done,
   output logic                                                 overflow
);
   localparam int N      = ARRAY_SIZE;
   localparam int K      = K_DIM;
   localparam int DW     = DATA_WIDTH;
   localparam int WW     = WEIGHT_WIDTH;
   localparam int AW     = ACCUM_WIDTH;
   localparam int PW     = DW + WW;
   localparam int SW     = ((PW > AW) ? PW : AW) + 1;
   localparam int IW     = (N > 1) ? $clog2(N) : 1;
   localparam int LAST_T = K + 2*N - 2;
   localparam int CW     = $clog2(LAST_T + 2);

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [DW*N*K-1:0] r_mat_a;
   logic [WW*K*N-1:0] r_mat_b;
   logic [DW-1:0]     r_skew_a [N][N];
   logic [WW-1:0]     r_skew_b [N][N];
   logic [AW-1:0]     r_acc    [N][N];
   logic [AW-1:0]     w_acc_nxt[N][N];
   logic [DW-1:0]     w_a_in   [N][N];
   logic [WW-1:0]     w_b_in   [N][N];
   logic [DW-1:0]     w_feed_a [N];
   logic [WW-1:0]     w_feed_b [N];
   logic [IW-1:0]     r_row;
   logic [IW-1:0]     w_sel_idx;
   logic [AW*N-1:0]   r_out_row;
   logic [AW*N-1:0]   w_sel_row;
   logic              r_out_valid;
   logic              r_done;

   // Edge feeders: A(i,k) enters row i at step k+i, B(k,j) enters column j at step k+j.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         w_feed_a[i] = '0;
         for (int unsigned k = 0; k < K; k++)
            if (r_cnt == CW'(i + k)) w_feed_a[i] = r_mat_a[(i*K + k)*DW +: DW];
      end
      for (int unsigned j = 0; j < N; j++) begin
         w_feed_b[j] = '0;
         for (int unsigned k = 0; k < K; k++)
            if (r_cnt == CW'(k + j)) w_feed_b[j] = r_mat_b[(k*N + j)*WW +: WW];
      end
   end

`ifdef SYSTOLIC_SAT_EN
   logic [N*N-1:0] w_clamp;
`endif

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [PW-1:0] w_ext_a;
         logic [PW-1:0] w_ext_b;
         logic [PW-1:0] w_prod;
         logic [SW-1:0] w_ext_acc;
         logic [SW-1:0] w_ext_prod;

         if (j == 0) begin : g_a_edge
            assign w_a_in[i][j] = w_feed_a[i];
         end else begin : g_a_pass
            assign w_a_in[i][j] = r_skew_a[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign w_b_in[i][j] = w_feed_b[j];
         end else begin : g_b_pass
            assign w_b_in[i][j] = r_skew_b[i-1][j];
         end

         assign w_ext_a    = {{(PW-DW){w_a_in[i][j][DW-1]}}, w_a_in[i][j]};
         assign w_ext_b    = {{(PW-WW){w_b_in[i][j][WW-1]}}, w_b_in[i][j]};
         assign w_prod     = w_ext_a * w_ext_b;
         assign w_ext_acc  = {{(SW-AW){r_acc[i][j][AW-1]}}, r_acc[i][j]};
         assign w_ext_prod = {{(SW-PW){w_prod[PW-1]}}, w_prod};

`ifdef SYSTOLIC_SAT_EN
         logic [SW-1:0] w_sum;
         logic [SW-AW:0] w_hi;
         assign w_sum = w_ext_acc + w_ext_prod;
         // Sum fits iff every bit from the AW-1 sign position upward agrees.
         assign w_hi = w_sum[SW-1:AW-1];
         assign w_clamp[i*N + j] = (w_hi != '0) && (w_hi != '1);
         assign w_acc_nxt[i][j] = !w_clamp[i*N + j] ? w_sum[AW-1:0] :
                                  w_sum[SW-1]       ? {1'b1, {(AW-1){1'b0}}} :
                                                      {1'b0, {(AW-1){1'b1}}};
`else
         assign w_acc_nxt[i][j] = AW'(w_ext_acc + w_ext_prod);
`endif
      end
   end

   // Next row to present: current row when loading, following row while one is on the output.
   assign w_sel_idx = r_out_valid ? r_row + 1'b1 : r_row;

   always_comb begin
      w_sel_row = '0;
      for (int unsigned r = 0; r < N; r++)
         if (w_sel_idx == IW'(r))
            for (int unsigned j = 0; j < N; j++) w_sel_row[j*AW +: AW] = r_acc[r][j];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mat_a     <= '0;
         r_mat_b     <= '0;
         r_row       <= '0;
         r_out_row   <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++) begin
               r_acc[i][j]    <= '0;
               r_skew_a[i][j] <= '0;
               r_skew_b[i][j] <= '0;
            end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_COMPUTE;
                  r_cnt   <= '0;
                  r_mat_a <= matrix_a_flat;
                  r_mat_b <= matrix_b_flat;
                  for (int unsigned i = 0; i < N; i++)
                     for (int unsigned j = 0; j < N; j++) begin
                        r_skew_a[i][j] <= '0;
                        r_skew_b[i][j] <= '0;
                        if (!acc_mode) r_acc[i][j] <= '0;
                     end
               end
            end
            S_COMPUTE: begin
               for (int unsigned i = 0; i < N; i++)
                  for (int unsigned j = 0; j < N; j++) begin
                     r_acc[i][j]    <= w_acc_nxt[i][j];
                     r_skew_a[i][j] <= w_a_in[i][j];
                     r_skew_b[i][j] <= w_b_in[i][j];
                  end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(LAST_T)) begin
                  r_state <= S_DRAIN;
                  r_row   <= '0;
               end
            end
            S_DRAIN: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_row   <= w_sel_row;
               end else if (out_ready) begin
                  if (r_row == IW'(N - 1)) begin
                     r_out_valid <= 1'b0;
                     r_row       <= '0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_row     <= r_row + 1'b1;
                     r_out_row <= w_sel_row;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SYSTOLIC_SAT_EN
   logic r_overflow;
   always_ff @(posedge clk) begin
      if (rst)                                 r_overflow <= 1'b0;
      else if (r_state == S_IDLE && start)     r_overflow <= 1'b0;
      else if (r_state == S_COMPUTE && |w_clamp) r_overflow <= 1'b1;
   end
   assign overflow = r_overflow;
`else
   assign overflow = 1'b0;
`endif

   assign busy        = (r_state != S_IDLE);
   assign out_valid   = r_out_valid;
   assign out_row_idx = r_row;
   assign out_row     = r_out_row;
   assign done        = r_done;
endmodule

// File: doc/systolic_matmul_tile.md
SYSTOLIC_MATMUL_TILE -- requirements
Module: systolic_matmul_tile

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 4, meaning PE grid dimension N (N x N output tile).
REQ-002 SHALL have parameter K_DIM, default 4, meaning inner dimension K, with K >= 1.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning signed A element width.
REQ-004 SHALL have parameter WEIGHT_WIDTH, default 8, meaning signed B element width.
REQ-005 SHALL have parameter ACCUM_WIDTH, default 32, meaning signed accumulator and result width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, which requests an operation.
REQ-009 SHALL have port acc_mode, input, 1, sampled with start: 0 = C=A*B, 1 = C+=A*B.
REQ-010 SHALL have port matrix_a_flat, input, DATA_WIDTH*N*K_DIM, with A(i,k) at bit offset (i*K_DIM+k)*DATA_WIDTH.
REQ-011 SHALL have port matrix_b_flat, input, WEIGHT_WIDTH*K_DIM*N, with B(k,j) at bit offset (k*N+j)*WEIGHT_WIDTH.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port out_valid, output, 1, result row available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the row.
REQ-015 SHALL have port out_row_idx, output, max(1,$clog2(N)), index of the row presented.
REQ-016 SHALL have port out_row, output, ACCUM_WIDTH*N, with C(row,j) at offset j*ACCUM_WIDTH.
REQ-017 SHALL have port done, output, 1, a one-cycle pulse after the last row is accepted.
REQ-018 SHALL have port overflow, output, 1, sticky saturation flag (see Configuration).

Function
REQ-019 SHALL implement states IDLE, COMPUTE, DRAIN, DONE.
REQ-020 In IDLE, start=1 SHALL latch both matrices and acc_mode and move to COMPUTE; operand changes after that edge SHALL have no effect.
REQ-021 start while not IDLE SHALL be ignored.
REQ-022 COMPUTE SHALL feed skewed operands: row i of A delayed i cycles, column j of B delayed j cycles. PE(i,j) SHALL accumulate A(i,k)*B(k,j) at relative cycle k+i+j.
REQ-023 COMPUTE SHALL last exactly K_DIM+2N-1 cycles. out_valid SHALL first rise exactly K_DIM+2N cycles after the start edge.
REQ-024 On entry to COMPUTE with acc_mode=0, accumulators SHALL clear before the first MAC. With acc_mode=1 they SHALL keep their prior values.
REQ-025 Products SHALL be full-precision signed, sign-extended to ACCUM_WIDTH before addition.
REQ-026 DRAIN SHALL present rows 0..N-1 in order. A row transfers on a cycle with out_valid and out_ready both high; out_row_idx then advances.
REQ-027 While out_valid=1 and out_ready=0, out_row and out_row_idx SHALL hold stable.
REQ-028 Transfer of row N-1 SHALL enter DONE. DONE SHALL assert done for one cycle, then return to IDLE.
REQ-029 Accumulators SHALL retain results after DONE, for use by a later acc_mode=1 operation.

Reset
REQ-030 While rst=1 the block SHALL force IDLE. All outputs SHALL be 0: busy, out_valid, out_row_idx, out_row, done and overflow.
REQ-031 Reset SHALL zero all accumulators and skew registers, including mid-COMPUTE or mid-DRAIN. No partial row SHALL be emitted afterwards.

Configuration
REQ-032 With SYSTOLIC_SAT_EN defined, each accumulate SHALL saturate to [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1]. Any clamp SHALL set overflow, which stays set until rst or the next start.
REQ-033 Without SYSTOLIC_SAT_EN, accumulation SHALL wrap two's-complement and overflow SHALL be tied to 0.

Verification
REQ-034 N=2, K=2, A=[1,2;3,4], B=identity, acc_mode=0, out_ready=1 -> first out_valid 6 cycles after start; rows [1,2] then [3,4]; done pulses once.
REQ-035 Repeat REQ-034 immediately with acc_mode=1 -> rows [2,4] then [6,8].
REQ-036 Signed check, N=2, K=2: A=[-3,5;7,-1], B=[-128,2;1,-4] -> [389,-26] and [-897,18].
REQ-037 Backpressure: hold out_ready=0 for 5 cycles after first out_valid -> row 0 is stable and not dropped; rows then follow in order; done occurs after row 1.
REQ-038 ACCUM_WIDTH=16, K=4, all A=32767, all B=127 -> with SYSTOLIC_SAT_EN: all 32767 and overflow=1; without it: all -508 and overflow=0.
REQ-039 Assert rst for 1 cycle mid-COMPUTE, then start with REQ-034 data and acc_mode=1 -> results [1,2],[3,4]; start pulsed while busy -> ignored.
